// File: rtl/bus_reg_bank_pkg.sv
// Shared constants for the bus register bank: bus direction and count direction encodings.
package bus_reg_bank_pkg;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_DRIVE = 1'b1;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/bus_reg_cell.sv
// One bank register: synchronous load or up/down count by a step, load taking priority.
// count_wrap_c flags carry/borrow of the count this cell would apply at the next edge.
module bus_reg_cell
    import bus_reg_bank_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 load_en_i,
    input  logic [BUS_WIDTH-1:0] load_data_i,
    input  logic                 count_en_i,
    input  logic                 count_dir_i,
    input  logic [BUS_WIDTH-1:0] step_i,
    output logic [BUS_WIDTH-1:0] value_o,
    output logic                 count_wrap_c
);

    logic [BUS_WIDTH-1:0] value_q;
    logic [BUS_WIDTH-1:0] value_d;
    logic [BUS_WIDTH:0]   sum_c;

    // The extra top bit of the widened add/subtract is the carry (up) or borrow (down).
    always_comb begin
        value_d      = value_q;
        count_wrap_c = 1'b0;
        if (count_dir_i == DIR_UP) begin
            sum_c = {1'b0, value_q} + {1'b0, step_i};
        end else begin
            sum_c = {1'b0, value_q} - {1'b0, step_i};
        end
        if (load_en_i) begin
            value_d = load_data_i;
        end else if (count_en_i) begin
            value_d      = sum_c[BUS_WIDTH-1:0];
            count_wrap_c = sum_c[BUS_WIDTH];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/bus_reg_bank.sv
// Bank of bus registers on a shared tri-state DATA bus with an independent counter port.
// Optional BUS_REG_BANK_STEP_EN adds a STEP port so counts move by STEP instead of 1.
module bus_reg_bank
    import bus_reg_bank_pkg::*;
#(
    parameter int unsigned         BUS_WIDTH  = 16,
    parameter int unsigned         NUM_REGS   = 4,
    parameter int unsigned         ADDR_WIDTH = 2,
    parameter logic [NUM_REGS-1:0] COUNT_MASK = {NUM_REGS{1'b1}}
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  RW,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  COUNT,
    input  logic                  COUNT_DIR,
    input  logic [ADDR_WIDTH-1:0] CNT_SEL,
`ifdef BUS_REG_BANK_STEP_EN
    input  logic [BUS_WIDTH-1:0]  STEP,
`endif
    inout  wire  [BUS_WIDTH-1:0]  DATA,
    output logic                  WRAP,
    output logic                  ZERO
);

    logic [BUS_WIDTH-1:0] reg_val [NUM_REGS];
    logic [NUM_REGS-1:0]  cell_wrap;
    logic [BUS_WIDTH-1:0] step;
    logic [BUS_WIDTH-1:0] drive_val;
    logic                 drive_en;
    logic                 addr_ok;
    logic                 sel_ok;
    logic                 wrap_q;
    logic                 wrap_d;

`ifdef BUS_REG_BANK_STEP_EN
    assign step = STEP;
`else
    assign step = BUS_WIDTH'(1);
`endif

    // Per-register decode; a load to the same register suppresses its count.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic load_hit;
        logic count_hit;

        assign load_hit  = ENABLE && (RW == RW_LOAD) && (ADDR == ADDR_WIDTH'(g));
        assign count_hit = COUNT && COUNT_MASK[g] && (CNT_SEL == ADDR_WIDTH'(g)) && !load_hit;

        bus_reg_cell #(
            .BUS_WIDTH (BUS_WIDTH)
        ) u_cell (
            .CLOCK        (CLOCK),
            .RESET        (RESET),
            .load_en_i    (load_hit),
            .load_data_i  (DATA),
            .count_en_i   (count_hit),
            .count_dir_i  (COUNT_DIR),
            .step_i       (step),
            .value_o      (reg_val[g]),
            .count_wrap_c (cell_wrap[g])
        );
    end

    // Unpopulated addresses read as 0 and report ZERO.
    always_comb begin
        addr_ok   = 32'(ADDR) < NUM_REGS;
        sel_ok    = 32'(CNT_SEL) < NUM_REGS;
        drive_val = '0;
        ZERO      = 1'b1;
        if (addr_ok) begin
            drive_val = reg_val[ADDR];
        end
        if (sel_ok) begin
            ZERO = (reg_val[CNT_SEL] == '0);
        end
    end

    assign drive_en = ENABLE && (RW == RW_DRIVE) && !RESET;
    assign DATA     = drive_en ? drive_val : {BUS_WIDTH{1'bz}};

    assign wrap_d = |cell_wrap;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign WRAP = wrap_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Bench for bus_reg_bank: three instances (full mask, reg0 count-masked, 3-register bank)
// checked against an array model; define BUS_REG_BANK_STEP_EN to exercise the STEP build.
module tb_bus_reg_bank;
    import bus_reg_bank_pkg::*;

    localparam int NI = 3;

    logic        CLOCK;
    logic        rst, en, rw, cnt, dir, tb_oe;
    logic [1:0]  addr, sel;
    logic [15:0] tb_val, step_v;
    wire  [15:0] data_a, data_b, data_c;
    logic        wrap_a, wrap_b, wrap_c;
    logic        zero_a, zero_b, zero_c;

    logic [15:0] obs_d [NI];
    logic        obs_w [NI];
    logic        obs_z [NI];

    logic [15:0] m     [NI][4];
    logic        mw    [NI];
    int          nregs [NI] = '{4, 4, 3};
    logic [3:0]  masks [NI] = '{4'b1111, 4'b1110, 4'b0111};

    int tests = 0;
    int fails = 0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    assign data_a = tb_oe ? tb_val : 16'hzzzz;
    assign data_b = tb_oe ? tb_val : 16'hzzzz;
    assign data_c = tb_oe ? tb_val : 16'hzzzz;

    always_comb begin
        obs_d[0] = data_a; obs_d[1] = data_b; obs_d[2] = data_c;
        obs_w[0] = wrap_a; obs_w[1] = wrap_b; obs_w[2] = wrap_c;
        obs_z[0] = zero_a; obs_z[1] = zero_b; obs_z[2] = zero_c;
    end

    bus_reg_bank #(.BUS_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(2), .COUNT_MASK(4'b1111)) u_dut_a (
        .CLOCK(CLOCK), .RESET(rst), .ENABLE(en), .RW(rw), .ADDR(addr), .COUNT(cnt),
        .COUNT_DIR(dir), .CNT_SEL(sel),
`ifdef BUS_REG_BANK_STEP_EN
        .STEP(step_v),
`endif
        .DATA(data_a), .WRAP(wrap_a), .ZERO(zero_a));

    bus_reg_bank #(.BUS_WIDTH(16), .NUM_REGS(4), .ADDR_WIDTH(2), .COUNT_MASK(4'b1110)) u_dut_b (
        .CLOCK(CLOCK), .RESET(rst), .ENABLE(en), .RW(rw), .ADDR(addr), .COUNT(cnt),
        .COUNT_DIR(dir), .CNT_SEL(sel),
`ifdef BUS_REG_BANK_STEP_EN
        .STEP(step_v),
`endif
        .DATA(data_b), .WRAP(wrap_b), .ZERO(zero_b));

    bus_reg_bank #(.BUS_WIDTH(16), .NUM_REGS(3), .ADDR_WIDTH(2), .COUNT_MASK(3'b111)) u_dut_c (
        .CLOCK(CLOCK), .RESET(rst), .ENABLE(en), .RW(rw), .ADDR(addr), .COUNT(cnt),
        .COUNT_DIR(dir), .CNT_SEL(sel),
`ifdef BUS_REG_BANK_STEP_EN
        .STEP(step_v),
`endif
        .DATA(data_c), .WRAP(wrap_c), .ZERO(zero_c));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic int cur_step();
`ifdef BUS_REG_BANK_STEP_EN
        return int'(step_v);
`else
        return 1;
`endif
    endfunction

    // Reference: registers as plain integers, counts done mod 2**16 with explicit wrap test.
    task automatic model_edge(input int k);
        int  v;
        bit  ld, cn;
        if (rst) begin
            for (int r = 0; r < 4; r++) m[k][r] = 16'h0000;
            mw[k] = 1'b0;
            return;
        end
        ld = en && (rw == RW_LOAD) && (int'(addr) < nregs[k]);
        cn = cnt && (int'(sel) < nregs[k]) && masks[k][sel] && !(ld && addr == sel);
        mw[k] = 1'b0;
        if (cn) begin
            v = int'(m[k][sel]);
            if (dir == DIR_UP) v = v + cur_step();
            else               v = v - cur_step();
            if (v > 65535) begin v = v - 65536; mw[k] = 1'b1; end
            if (v < 0)     begin v = v + 65536; mw[k] = 1'b1; end
            m[k][sel] = 16'(v);
        end
        if (ld) m[k][addr] = tb_val;
    endtask

    task automatic set(input bit r, input bit e, input bit w, input int a, input bit c,
                       input bit d, input int s, input logic [15:0] v, input logic [15:0] st);
        rst = r; en = e; rw = w; addr = 2'(a); cnt = c; dir = d; sel = 2'(s);
        tb_val = v; step_v = st;
        tb_oe = r || !(e && w == RW_DRIVE);
    endtask

    // One clock: combinational checks mid-cycle, model update at the edge, WRAP after it.
    task automatic tick();
        logic [15:0] exp_d;
        #4;
        for (int k = 0; k < NI; k++) begin
            if (!rst && en && rw == RW_DRIVE) begin
                exp_d = (int'(addr) < nregs[k]) ? m[k][addr] : 16'h0000;
                chk("drive", k, 32'(obs_d[k]), 32'(exp_d));
            end else if (tb_oe) begin
                chk("bus_released", k, 32'(obs_d[k]), 32'(tb_val));
            end
            chk("zero", k, 32'(obs_z[k]),
                32'((int'(sel) < nregs[k]) ? (m[k][sel] == 16'h0000) : 1'b1));
        end
        @(posedge CLOCK);
        for (int k = 0; k < NI; k++) model_edge(k);
        #1;
        for (int k = 0; k < NI; k++) chk("wrap", k, 32'(obs_w[k]), 32'(mw[k]));
    endtask

    task automatic rd(input int a);
        set(0, 1, RW_DRIVE, a, 0, DIR_UP, 0, 16'h0000, 16'h0001);
        tick();
    endtask

    initial begin
        set(1, 0, RW_LOAD, 0, 0, DIR_UP, 0, 16'h0000, 16'h0001);
        repeat (2) @(posedge CLOCK);
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 4; r++) m[k][r] = 16'h0000;
            mw[k] = 1'b0;
        end
        #1;

        // Reset while ENABLE/RW request a drive: bus must stay released.
        set(1, 1, RW_DRIVE, 1, 0, DIR_UP, 0, 16'hA5A5, 16'h0001);
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a);
            chk("t1_read_zero", 0, 32'(data_a), 32'h0000);
        end
        set(0, 0, RW_DRIVE, 0, 0, DIR_UP, 0, 16'h5A5A, 16'h0001);
        tick();

        set(0, 1, RW_LOAD, 2, 0, DIR_UP, 0, 16'h1234, 16'h0001);
        tick();
        rd(2);
        chk("t2_read_loaded", 0, 32'(data_a), 32'h1234);
        for (int a = 0; a < 4; a++) begin
            if (a != 2) begin
                rd(a);
                chk("t2_others_zero", 0, 32'(data_a), 32'h0000);
            end
        end

        set(0, 1, RW_LOAD, 1, 0, DIR_UP, 0, 16'hFFFF, 16'h0001);
        tick();
        set(0, 0, RW_LOAD, 0, 1, DIR_UP, 1, 16'h0F0F, 16'h0001);
        tick();
        chk("t3_wrap_up", 0, 32'(wrap_a), 32'h1);
        chk("t3_zero", 0, 32'(zero_a), 32'h1);
        tick();
        chk("t3_no_wrap", 0, 32'(wrap_a), 32'h0);
        rd(1);
        chk("t3_reg1", 0, 32'(data_a), 32'h0001);

        set(0, 0, RW_LOAD, 0, 1, DIR_DOWN, 0, 16'h3C3C, 16'h0001);
        tick();
        chk("t4_wrap_down", 0, 32'(wrap_a), 32'h1);
        chk("t4_masked_no_wrap", 1, 32'(wrap_b), 32'h0);
        rd(0);
        chk("t4_reg0", 0, 32'(data_a), 32'hFFFF);
        chk("t4_masked_reg0", 1, 32'(data_b), 32'h0000);

        set(0, 1, RW_LOAD, 0, 0, DIR_UP, 0, 16'h0005, 16'h0001);
        tick();
        set(0, 1, RW_LOAD, 3, 1, DIR_UP, 3, 16'h00AA, 16'h0001);
        tick();
        chk("t5_same_reg_wrap", 0, 32'(wrap_a), 32'h0);
        set(0, 1, RW_LOAD, 3, 1, DIR_UP, 0, 16'h00AA, 16'h0001);
        tick();
        rd(3);
        chk("t5_reg3", 0, 32'(data_a), 32'h00AA);
        chk("t5_unpopulated_read", 2, 32'(data_c), 32'h0000);
        rd(0);
        chk("t5_reg0", 0, 32'(data_a), 32'h0006);

`ifdef BUS_REG_BANK_STEP_EN
        set(0, 1, RW_LOAD, 2, 0, DIR_UP, 0, 16'hFFF0, 16'h0020);
        tick();
        set(0, 0, RW_LOAD, 0, 1, DIR_UP, 2, 16'h0000, 16'h0020);
        tick();
        chk("t6_step_wrap", 0, 32'(wrap_a), 32'h1);
        rd(2);
        chk("t6_step_reg2", 0, 32'(data_a), 32'h0010);
        set(0, 0, RW_LOAD, 0, 1, DIR_UP, 2, 16'h0000, 16'h0000);
        tick();
        chk("t6_step_zero_nowrap", 0, 32'(wrap_a), 32'h0);
`endif
        // Reset must beat a count that would otherwise wrap.
        set(0, 1, RW_LOAD, 2, 0, DIR_UP, 0, 16'hFFFF, 16'h0001);
        tick();
        set(1, 0, RW_LOAD, 0, 1, DIR_UP, 2, 16'h0000, 16'h0001);
        tick();
        chk("t6_reset_wrap", 0, 32'(wrap_a), 32'h0);
        chk("t6_reset_zero", 0, 32'(zero_a), 32'h1);

        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v, st;
            case ($urandom_range(0, 4))
                0:       v = 16'h0000;
                1:       v = 16'hFFFF;
                2:       v = 16'hFFFE;
                3:       v = 16'h0001;
                default: v = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       st = 16'h0000;
                1:       st = 16'hFFFF;
                2:       st = 16'h0020;
                default: st = 16'($urandom);
            endcase
            set(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), v, st);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
